div_unit: RTL
=============

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the EX stage of the 5-stage MIPS pipeline.
- It consumes the decoded DIV/DIVU request (ALU control plus HILO write enable) that the controller delivers to EX.
- It produces quotient (LO) and remainder (HI) for the HILO register.
- It raises a stall request to the hazard logic, which holds StallE and the upstream stages until the result is ready.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 5, iteration counter width; must equal log2(WIDTH).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  EX holds a DIV/DIVU (decoded from ALUControlE with HiloWriteE).
- signed_div  input  1  1 = DIV (signed), 0 = DIVU.
- flush  input  1  annul the in-flight division (FlushE or exception).
- dividend  input  WIDTH  rs operand, forwarded EX value.
- divisor  input  WIDTH  rt operand, forwarded EX value.
- stall  output  1  busy; hazard unit ORs this into the EX/ID/IF stall.
- ready  output  1  one-cycle pulse: results valid, HILO write this cycle.
- quotient  output  WIDTH  to LO.
- remainder  output  WIDTH  to HI.

Behaviour:
- States: IDLE, DIV, DONE, held in a 2-bit registered state.
- Reset (async, rst=1): state=IDLE, counter=0, quotient=0, remainder=0, ready=0, all internal working registers=0.
- stall is combinational: stall = (state==IDLE & start & ~flush) | (state==DIV).

IDLE:
- start=1 & flush=0: latch |dividend| and |divisor| when signed_div=1, raw values otherwise.
- In the same cycle, latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend), both only when signed.
- Also clear the partial remainder, set counter=0 and go to DIV.
- start=0 or flush=1: stay in IDLE.

DIV:
- Each cycle: shift {partial_rem, quot} left by 1.
- Trial-subtract the divisor from the upper WIDTH+1 bits. If the result is non-negative, keep it and set quot[0]=1.
- Then counter++.
- When counter==WIDTH-1, the last iteration completes this cycle and the next state is DONE.
- The quotient and remainder output registers load in the same edge, with the sign fix applied:
  - quotient = sign_q ? -quot : quot.
  - remainder = sign_r ? -rem : rem.
- flush=1 in any DIV cycle: go to IDLE next edge. ready is never asserted and the output registers keep their old values.
- start is ignored while in DIV.

DONE:
- ready=1 for exactly this cycle and stall=0, so the DIV instruction advances and HILO is written.
- Next state is always IDLE. start in DONE is ignored; the next instruction arrives in IDLE one cycle later.
- flush in DONE has no effect on ready. Pipeline write suppression is the pipeline's responsibility.

Latency:
- Start accepted in cycle N. stall is high in cycles N..N+32 (33 cycles).
- ready is high in cycle N+33.

Divide by zero (divisor==0):
- No trap; the iteration runs normally.
- Unsigned result: quotient=all ones, remainder=dividend.
- Signed result: the sign fix applies to these raw values. It is deterministic, and the bench checks these exact values.

Overflow (signed 0x80000000 / 0xFFFFFFFF):
- The natural path gives quotient=0x80000000, remainder=0. No special case.

Hold and reset:
- quotient and remainder hold their values until the next DONE.
- Reset mid-division returns to IDLE immediately. stall drops asynchronously with reset.

Test Plan:
1. DIVU 100/7: start one cycle -> stall high 33 cycles, ready pulse at N+33, quotient=14, remainder=2, ready low at N+34.
2. DIV -7/2 (0xFFFFFFF9, 2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Then DIV 7/-2 -> quotient=-3, remainder=1.
3. DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0. DIVU 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
4. DIVU 0x1234/0 -> quotient=0xFFFFFFFF, remainder=0x1234, latency unchanged at 33 stall cycles.
5. Flush at iteration 10 -> IDLE next cycle, stall low, no ready, outputs keep the previous result. A new start 2 cycles later completes with the correct result.
6. Async rst asserted mid-DIV between clock edges -> stall, ready and outputs go to 0 immediately. Back-to-back DIVs (start asserted in the cycle after DONE) each give ready exactly once with the correct results.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces the quotient (to LO) and remainder (to HI) 33 cycles after a start is
// accepted, and requests a pipeline stall while the division is in flight.
//
// Ports:
//   clk        pipeline clock, rising edge
//   rst        asynchronous active-high reset
//   start      EX holds a DIV/DIVU instruction
//   signed_div 1 = DIV (signed), 0 = DIVU
//   flush      annul the in-flight division
//   dividend   rs operand (forwarded)
//   divisor    rt operand (forwarded)
//   stall      combinational busy, ORed into the EX/ID/IF stall
//   ready      one-cycle pulse, quotient/remainder valid for the HILO write
//   quotient   result to LO
//   remainder  result to HI
module div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             stall,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } stateType;

    stateType         state;
    stateType         stateNext;
    logic             readyNext;

    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] divisorReg;
    logic [WIDTH-1:0] partRem;
    logic [WIDTH-1:0] quot;
    logic             signQ;
    logic             signR;

    logic             accept;
    logic             lastIter;
    logic [WIDTH-1:0] absDividend;
    logic [WIDTH-1:0] absDivisor;
    logic [WIDTH:0]   shiftUpper;
    logic             canSub;
    logic [WIDTH-1:0] remStep;
    logic [WIDTH-1:0] quotStep;

    assign accept   = (state == IDLE) && start && !flush;
    assign lastIter = (counter == CNT_W'(WIDTH - 1));

    // Gated by rst so the stall request falls together with the async reset.
    assign stall = !rst && (accept || (state == DIV));

    // Magnitudes for signed division; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    assign absDividend = (signed_div && dividend[WIDTH-1]) ? (WIDTH'(0) - dividend) : dividend;
    assign absDivisor  = (signed_div && divisor[WIDTH-1])  ? (WIDTH'(0) - divisor)  : divisor;

    // One restoring step: shift in the next dividend bit, trial-subtract.
    // The subtraction result is always below the divisor, so WIDTH bits suffice.
    assign shiftUpper = {partRem, quot[WIDTH-1]};
    assign canSub     = (shiftUpper >= {1'b0, divisorReg});
    assign remStep    = canSub ? (shiftUpper[WIDTH-1:0] - divisorReg) : shiftUpper[WIDTH-1:0];
    assign quotStep   = {quot[WIDTH-2:0], canSub};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and ready decode
    always_comb begin
        stateNext = state;
        readyNext = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = DIV;
                end
            end
            DIV: begin
                if (flush) begin
                    stateNext = IDLE;
                end else if (lastIter) begin
                    stateNext = DONE;
                    readyNext = 1'b1;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter    <= '0;
            divisorReg <= '0;
            partRem    <= '0;
            quot       <= '0;
            signQ      <= 1'b0;
            signR      <= 1'b0;
            quotient   <= '0;
            remainder  <= '0;
            ready      <= 1'b0;
        end else begin
            ready <= readyNext;
            case (state)
                IDLE: begin
                    if (accept) begin
                        quot       <= absDividend;
                        divisorReg <= absDivisor;
                        partRem    <= '0;
                        counter    <= '0;
                        signQ      <= signed_div && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        signR      <= signed_div && dividend[WIDTH-1];
                    end
                end
                DIV: begin
                    if (!flush) begin
                        partRem <= remStep;
                        quot    <= quotStep;
                        counter <= counter + CNT_W'(1);
                        if (lastIter) begin
                            quotient  <= signQ ? (WIDTH'(0) - quotStep) : quotStep;
                            remainder <= signR ? (WIDTH'(0) - remStep)  : remStep;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
